// File: rtl/line_fill_responder.sv
// line_fill_responder: memory-side responder for the cache miss bus; returns whole
// lines of BEATS beats from a side-loaded word array after a fixed read latency.
module line_fill_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 1024,
    parameter int BEATS          = 8,
    parameter int READ_LATENCY   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         bus_reqcyc,
    output logic                         bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0]    bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]     bus_reqtag,
    output logic                         bus_respcyc,
    input  logic                         bus_respack,
    output logic [BUS_DATA_WIDTH-1:0]    bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]     bus_resptag,
    input  logic                         init_we,
    input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
    input  logic [BUS_DATA_WIDTH-1:0]    init_data
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int BW = $clog2(BEATS);
    localparam int LW = $clog2(READ_LATENCY + 2);

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT, S_SEND} state_t;

    state_t                    state_q, state_d;
    logic [LW-1:0]             lat_q, lat_d;
    logic [BW-1:0]             beat_q, beat_d;
    logic [AW-BW-1:0]          line_q, line_d;
    logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic                      unused_addr_bits;

    // Only the line index within the array matters; byte offset and upper bits wrap away.
    assign unused_addr_bits = ^{bus_req[BUS_DATA_WIDTH-1:AW+3], bus_req[BW+2:0]};

    always_ff @(posedge clk) begin
        if (init_we) mem[init_addr] <= init_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            line_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        beat_d      = beat_q;
        line_d      = line_q;
        tag_d       = tag_q;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus_reqcyc) begin
                    state_d = S_ACK;
                    line_d  = bus_req[AW+2:BW+3];
                    tag_d   = bus_reqtag;
                end
            end
            S_ACK: begin
                bus_reqack = 1'b1;
                lat_d      = LW'(READ_LATENCY);
                state_d    = (READ_LATENCY == 0) ? S_SEND : S_WAIT;
            end
            S_WAIT: begin
                lat_d   = lat_q - LW'(1);
                state_d = (lat_q == LW'(1)) ? S_SEND : S_WAIT;
            end
            default: begin
                bus_respcyc = 1'b1;
                if (bus_respack) begin
                    beat_d  = (beat_q == BW'(BEATS - 1)) ? '0 : beat_q + BW'(1);
                    state_d = (beat_q == BW'(BEATS - 1)) ? S_IDLE : S_SEND;
                end
            end
        endcase
    end

    // Asynchronous array read so a same-word preload write shows on the next cycle.
    assign bus_resp    = bus_respcyc ? mem[{line_q, beat_q}] : '0;
    assign bus_resptag = bus_respcyc ? tag_q : '0;
endmodule

// File: tb/tb_line_fill_responder.sv
// tb_line_fill_responder: directed vector table of line requests plus hand-written
// sequences for stalls, back-to-back requests, mid-burst writes and mid-burst reset.
module tb_line_fill_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bus_reqcyc = 1'b0;
    logic        bus_reqack;
    logic [63:0] bus_req = '0;
    logic [12:0] bus_reqtag = '0;
    logic        bus_respcyc;
    logic        bus_respack = 1'b0;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        init_we = 1'b0;
    logic [9:0]  init_addr = '0;
    logic [63:0] init_data = '0;

    int total = 0;
    int bad = 0;

    line_fill_responder dut (
        .clk(clk), .reset(reset),
        .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack),
        .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [12:0] tag;
        logic [9:0]  base;
        bit          stall;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // From the ACK cycle, the first beat is READ_LATENCY+1 cycles later.
    task automatic wait_first();
        int n = 0;
        int acks = 0;
        while (!bus_respcyc && n < 30) begin
            step();
            n++;
            acks += int'(bus_reqack);
        end
        chk("latency", 64'(n), 64'd5);
        chk("extra_ack", 64'(acks), 64'd0);
    endtask

    task automatic run_req(input logic [63:0] addr, input logic [12:0] tag);
        bus_reqcyc = 1'b1;
        bus_req    = addr;
        bus_reqtag = tag;
        step();
        chk("reqack", 64'(bus_reqack), 64'd1);
        chk("no_resp_in_ack", 64'(bus_respcyc), 64'd0);
        bus_reqcyc = 1'b0;
        wait_first();
    endtask

    task automatic beats(input logic [9:0] base, input logic [12:0] tag, input bit stall);
        for (int b = 0; b < 8; b++) begin
            logic [63:0] exp = 64'h1000 + 64'((base + 10'(b)) & 10'h3ff);
            chk("beat_valid", 64'(bus_respcyc), 64'd1);
            chk("beat_data", bus_resp, exp);
            chk("beat_tag", 64'(bus_resptag), 64'(tag));
            if (stall && b[0]) begin
                bus_respack = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    step();
                    chk("stall_valid", 64'(bus_respcyc), 64'd1);
                    chk("stall_data", bus_resp, exp);
                end
            end
            bus_respack = 1'b1;
            step();
        end
        chk("end_idle", 64'(bus_respcyc), 64'd0);
        bus_respack = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{64'h40, 13'd5, 10'd8, 1'b0};
        vecs[1] = '{64'h47, 13'd6, 10'd8, 1'b0};
        vecs[2] = '{64'h40, 13'd5, 10'd8, 1'b1};
        vecs[3] = '{64'h2000, 13'd7, 10'd0, 1'b0};
        vecs[4] = '{64'h1ffc0, 13'h1fff, 10'd1016, 1'b1};
        vecs[5] = '{64'hffff_ffff_ffff_ffff, 13'd0, 10'd1016, 1'b0};

        step();
        step();
        chk("rst_reqack", 64'(bus_reqack), 64'd0);
        chk("rst_respcyc", 64'(bus_respcyc), 64'd0);
        chk("rst_resp", bus_resp, 64'd0);
        chk("rst_resptag", 64'(bus_resptag), 64'd0);
        reset = 1'b0;

        for (int w = 0; w < 1024; w++) begin
            init_we   = 1'b1;
            init_addr = 10'(w);
            init_data = 64'h1000 + 64'(w);
            step();
        end
        init_we = 1'b0;

        foreach (vecs[i]) begin
            bus_respack = vecs[i].stall ? 1'b0 : 1'b1;
            run_req(vecs[i].addr, vecs[i].tag);
            beats(vecs[i].base, vecs[i].tag, vecs[i].stall);
        end

        // Request held high across a burst: one ack, then the next request one cycle after IDLE.
        bus_respack = 1'b1;
        bus_reqcyc  = 1'b1;
        bus_req     = 64'h40;
        bus_reqtag  = 13'd9;
        step();
        chk("hold_ack1", 64'(bus_reqack), 64'd1);
        bus_req    = 64'h2000;
        bus_reqtag = 13'd10;
        wait_first();
        beats(10'd8, 13'd9, 1'b0);
        chk("hold_idle_noack", 64'(bus_reqack), 64'd0);
        step();
        chk("hold_ack2", 64'(bus_reqack), 64'd1);
        bus_reqcyc = 1'b0;
        wait_first();
        beats(10'd0, 13'd10, 1'b0);

        // Preload write to the word on the bus shows up the following cycle.
        run_req(64'h80, 13'd11);
        chk("wr_before", bus_resp, 64'h1010);
        init_we   = 1'b1;
        init_addr = 10'd16;
        init_data = 64'hdead;
        step();
        init_we = 1'b0;
        chk("wr_after", bus_resp, 64'hdead);
        bus_respack = 1'b1;
        for (int b = 0; b < 8; b++) step();
        chk("wr_end_idle", 64'(bus_respcyc), 64'd0);
        bus_respack = 1'b0;
        init_we   = 1'b1;
        init_data = 64'h1010;
        step();
        init_we = 1'b0;

        // Reset at beat 3 aborts the burst; a fresh request restarts from beat 0.
        bus_respack = 1'b1;
        run_req(64'h100, 13'd12);
        for (int b = 0; b < 3; b++) step();
        chk("pre_rst_beat3", bus_resp, 64'h1023);
        reset = 1'b1;
        step();
        chk("mid_rst_respcyc", 64'(bus_respcyc), 64'd0);
        chk("mid_rst_resp", bus_resp, 64'd0);
        chk("mid_rst_tag", 64'(bus_resptag), 64'd0);
        reset = 1'b0;
        run_req(64'h100, 13'd3);
        beats(10'd32, 13'd3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
